breakout_ball_ctrl: RTL and testbench

- Owns the ball: position, direction, serve/miss/game-over sequencing and lives.
- Consumes the moveU/moveD/moveL/moveR bounce requests from the block-column collision modules (OR-combined at top level). Drives ball_x_l/ball_x_r/ball_y_t/ball_y_b back to those modules and ball_ON to the pixel mux.
- Sits beside the VGA sync and paddle logic in the 800x600 breakout top level. The paddle is vertical at the right edge; the block columns are at the left.

---
 rtl/breakout_pkg.sv | 39 +++
 rtl/breakout_ball_step.sv | 77 +++++++
 rtl/breakout_ball_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_breakout_ball_ctrl.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/breakout_pkg.sv
// breakout_pkg: screen constants, ball FSM state encoding, direction encodings
// and the coordinate clamp shared by the ball controller and its step logic.
package breakout_pkg;

    localparam int H_MAX = 799;
    localparam int V_MAX = 599;

    typedef enum logic [1:0] {
        ST_SERVE     = 2'd0,
        ST_MOVE      = 2'd1,
        ST_MISS      = 2'd2,
        ST_GAME_OVER = 2'd3
    } ball_state_e;

    typedef enum logic {
        DX_LEFT  = 1'b0,
        DX_RIGHT = 1'b1
    } dir_x_e;

    typedef enum logic {
        DY_UP   = 1'b0,
        DY_DOWN = 1'b1
    } dir_y_e;

    // Clamp a signed intermediate coordinate into [0, i_hi].
    function automatic logic [10:0] clamp_coord(input logic signed [11:0] i_val,
                                                input logic [10:0]        i_hi);
        logic [10:0] v_res;
        if (i_val < 12'sd0) begin
            v_res = 11'd0;
        end else if (i_val > $signed({1'b0, i_hi})) begin
            v_res = i_hi;
        end else begin
            v_res = i_val[10:0];
        end
        return v_res;
    endfunction

endpackage

// File: rtl/breakout_ball_step.sv
// breakout_ball_step: combinational per-frame ball update. Resolves bounce
// requests, wall reflections and the paddle, then steps and clamps the position.
module breakout_ball_step
    import breakout_pkg::*;
#(
    parameter int BALL_SIZE  = 8,
    parameter int SPEED      = 2,
    parameter int PADDLE_X_L = 760
) (
    input  logic [10:0] i_x_l,
    input  logic [10:0] i_y_t,
    input  dir_x_e      i_dx,
    input  dir_y_e      i_dy,
    input  logic        i_mv_u,
    input  logic        i_mv_d,
    input  logic        i_mv_l,
    input  logic        i_mv_r,
    input  logic [10:0] i_paddle_y_t,
    input  logic [10:0] i_paddle_y_b,
    output dir_x_e      o_dx,
    output dir_y_e      o_dy,
    output logic [10:0] o_x_l,
    output logic [10:0] o_y_t
);

    localparam logic signed [11:0] L_SPEED = 12'(SPEED);
    localparam logic [10:0]        X_HI    = 11'(H_MAX - BALL_SIZE + 1);
    localparam logic [10:0]        Y_HI    = 11'(V_MAX - BALL_SIZE + 1);

    logic [10:0]        w_x_r;
    logic [10:0]        w_y_b;
    dir_x_e             w_dx_flag;
    dir_x_e             w_dx_wall;
    dir_y_e             w_dy_flag;
    logic               w_left_wall;
    logic               w_top_wall;
    logic               w_bot_wall;
    logic               w_paddle_hit;
    logic signed [11:0] w_x_sum;
    logic signed [11:0] w_y_sum;

    assign w_x_r = i_x_l + 11'(BALL_SIZE - 1);
    assign w_y_b = i_y_t + 11'(BALL_SIZE - 1);

    // Bounce requests: both sides at once means a corner hit, so reflect.
    assign w_dx_flag = (i_mv_r && i_mv_l) ? dir_x_e'(~i_dx) :
                       i_mv_r             ? DX_RIGHT       :
                       i_mv_l             ? DX_LEFT        : i_dx;
    assign w_dy_flag = (i_mv_d && i_mv_u) ? dir_y_e'(~i_dy) :
                       i_mv_d             ? DY_DOWN        :
                       i_mv_u             ? DY_UP          : i_dy;

    // Walls: left, top and bottom reflect; the right side is the miss zone.
    assign w_left_wall = (i_x_l < 11'(SPEED)) && (w_dx_flag == DX_LEFT);
    assign w_top_wall  = (i_y_t < 11'(SPEED)) && (w_dy_flag == DY_UP);
    assign w_bot_wall  = (w_y_b > 11'(V_MAX - SPEED)) && (w_dy_flag == DY_DOWN);
    assign w_dx_wall   = w_left_wall ? DX_RIGHT : w_dx_flag;
    assign o_dy        = w_top_wall ? DY_DOWN : (w_bot_wall ? DY_UP : w_dy_flag);

    // Paddle face catch window is one step wide in front of the paddle.
    assign w_paddle_hit = (w_dx_wall == DX_RIGHT) &&
                          (w_x_r >= 11'(PADDLE_X_L - SPEED)) &&
                          (w_x_r <= 11'(PADDLE_X_L)) &&
                          (w_y_b >= i_paddle_y_t) &&
                          (i_y_t <= i_paddle_y_b);
    assign o_dx = w_paddle_hit ? DX_LEFT : w_dx_wall;

    // Signed step so that a move past zero clamps instead of wrapping.
    assign w_x_sum = (o_dx == DX_RIGHT) ? ($signed({1'b0, i_x_l}) + L_SPEED)
                                        : ($signed({1'b0, i_x_l}) - L_SPEED);
    assign w_y_sum = (o_dy == DY_DOWN)  ? ($signed({1'b0, i_y_t}) + L_SPEED)
                                        : ($signed({1'b0, i_y_t}) - L_SPEED);

    assign o_x_l = clamp_coord(w_x_sum, X_HI);
    assign o_y_t = clamp_coord(w_y_sum, Y_HI);

endmodule

// File: rtl/breakout_ball_ctrl.sv
// breakout_ball_ctrl: ball owner for the breakout top level. Sequences
// serve / move / miss / game-over, latches block-hit bounce requests between
// frame ticks and counts lives.
module breakout_ball_ctrl
    import breakout_pkg::*;
#(
    parameter int BALL_SIZE   = 8,
    parameter int SPEED       = 2,
    parameter int SERVE_X     = 700,
    parameter int SERVE_Y     = 296,
    parameter int PADDLE_X_L  = 760,
    parameter int MISS_X      = 792,
    parameter int LIVES       = 3,
    parameter int MISS_FRAMES = 60
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_tick,
    input  logic        btn_launch,
    input  logic        moveU,
    input  logic        moveD,
    input  logic        moveL,
    input  logic        moveR,
    input  logic [10:0] paddle_y_t,
    input  logic [10:0] paddle_y_b,
    input  logic [10:0] pix_x,
    input  logic [10:0] pix_y,
    output logic [10:0] ball_x_l,
    output logic [10:0] ball_x_r,
    output logic [10:0] ball_y_t,
    output logic [10:0] ball_y_b,
    output logic        ball_ON,
    output logic [1:0]  lives,
    output logic        miss,
    output logic        game_over
);

    localparam int CNT_W = $clog2(MISS_FRAMES);

    ball_state_e       r_state;
    logic [10:0]       r_x_l;
    logic [10:0]       r_x_r;
    logic [10:0]       r_y_t;
    logic [10:0]       r_y_b;
    dir_x_e            r_dx;
    dir_y_e            r_dy;
    logic [1:0]        r_lives;
    logic              r_miss;
    logic              r_game_over;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_btn_q;
    logic              r_pend_u;
    logic              r_pend_d;
    logic              r_pend_l;
    logic              r_pend_r;

    ball_state_e       w_state_nxt;
    logic [10:0]       w_x_l_nxt;
    logic [10:0]       w_y_t_nxt;
    dir_x_e            w_dx_nxt;
    dir_y_e            w_dy_nxt;
    logic [1:0]        w_lives_nxt;
    logic              w_miss_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              w_launch;
    dir_x_e            w_step_dx;
    dir_y_e            w_step_dy;
    logic [10:0]       w_step_x;
    logic [10:0]       w_step_y;
    logic              w_in_box;

    assign w_launch = btn_launch & ~r_btn_q;

    breakout_ball_step #(
        .BALL_SIZE  (BALL_SIZE),
        .SPEED      (SPEED),
        .PADDLE_X_L (PADDLE_X_L)
    ) u_step (
        .i_x_l        (r_x_l),
        .i_y_t        (r_y_t),
        .i_dx         (r_dx),
        .i_dy         (r_dy),
        .i_mv_u       (r_pend_u | moveU),
        .i_mv_d       (r_pend_d | moveD),
        .i_mv_l       (r_pend_l | moveL),
        .i_mv_r       (r_pend_r | moveR),
        .i_paddle_y_t (paddle_y_t),
        .i_paddle_y_b (paddle_y_b),
        .o_dx         (w_step_dx),
        .o_dy         (w_step_dy),
        .o_x_l        (w_step_x),
        .o_y_t        (w_step_y)
    );

    // Next-state and datapath decisions for the ball sequencer.
    always_comb begin
        w_state_nxt = r_state;
        w_x_l_nxt   = r_x_l;
        w_y_t_nxt   = r_y_t;
        w_dx_nxt    = r_dx;
        w_dy_nxt    = r_dy;
        w_lives_nxt = r_lives;
        w_miss_nxt  = 1'b0;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_SERVE: begin
                w_x_l_nxt = 11'(SERVE_X);
                w_y_t_nxt = 11'(SERVE_Y);
                w_dx_nxt  = DX_LEFT;
                w_dy_nxt  = DY_UP;
                w_cnt_nxt = '0;
                if (w_launch) begin
                    w_state_nxt = ST_MOVE;
                end else begin
                    w_state_nxt = ST_SERVE;
                end
            end
            ST_MOVE: begin
                if (frame_tick && (r_x_l >= 11'(MISS_X))) begin
                    w_state_nxt = ST_MISS;
                    w_miss_nxt  = 1'b1;
                    w_lives_nxt = (r_lives == 2'd0) ? 2'd0 : (r_lives - 2'd1);
                    w_cnt_nxt   = '0;
                end else if (frame_tick) begin
                    w_x_l_nxt = w_step_x;
                    w_y_t_nxt = w_step_y;
                    w_dx_nxt  = w_step_dx;
                    w_dy_nxt  = w_step_dy;
                end else begin
                    w_state_nxt = ST_MOVE;
                end
            end
            ST_MISS: begin
                if (frame_tick && (r_cnt == CNT_W'(MISS_FRAMES - 1))) begin
                    w_cnt_nxt = '0;
                    if (r_lives == 2'd0) begin
                        w_state_nxt = ST_GAME_OVER;
                    end else begin
                        w_state_nxt = ST_SERVE;
                        w_x_l_nxt   = 11'(SERVE_X);
                        w_y_t_nxt   = 11'(SERVE_Y);
                    end
                end else if (frame_tick) begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end else begin
                    w_state_nxt = ST_MISS;
                end
            end
            ST_GAME_OVER: begin
                w_state_nxt = ST_GAME_OVER;
            end
            default: begin
                w_state_nxt = ST_SERVE;
            end
        endcase
    end

    // Sequencer state, ball box, lives and status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_SERVE;
            r_x_l       <= 11'(SERVE_X);
            r_x_r       <= 11'(SERVE_X + BALL_SIZE - 1);
            r_y_t       <= 11'(SERVE_Y);
            r_y_b       <= 11'(SERVE_Y + BALL_SIZE - 1);
            r_dx        <= DX_LEFT;
            r_dy        <= DY_UP;
            r_lives     <= 2'(LIVES);
            r_miss      <= 1'b0;
            r_game_over <= 1'b0;
            r_cnt       <= '0;
            r_btn_q     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_x_l       <= w_x_l_nxt;
            r_x_r       <= w_x_l_nxt + 11'(BALL_SIZE - 1);
            r_y_t       <= w_y_t_nxt;
            r_y_b       <= w_y_t_nxt + 11'(BALL_SIZE - 1);
            r_dx        <= w_dx_nxt;
            r_dy        <= w_dy_nxt;
            r_lives     <= w_lives_nxt;
            r_miss      <= w_miss_nxt;
            r_game_over <= (w_state_nxt == ST_GAME_OVER);
            r_cnt       <= w_cnt_nxt;
            r_btn_q     <= btn_launch;
        end
    end

    // Bounce requests arriving between frame ticks are held until the next tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pend_u <= 1'b0;
            r_pend_d <= 1'b0;
            r_pend_l <= 1'b0;
            r_pend_r <= 1'b0;
        end else if ((r_state == ST_SERVE) || frame_tick) begin
            r_pend_u <= 1'b0;
            r_pend_d <= 1'b0;
            r_pend_l <= 1'b0;
            r_pend_r <= 1'b0;
        end else begin
            r_pend_u <= r_pend_u | moveU;
            r_pend_d <= r_pend_d | moveD;
            r_pend_l <= r_pend_l | moveL;
            r_pend_r <= r_pend_r | moveR;
        end
    end

    assign w_in_box = (pix_x >= r_x_l) && (pix_x <= r_x_r) &&
                      (pix_y >= r_y_t) && (pix_y <= r_y_b);
    assign ball_ON  = w_in_box && ((r_state == ST_SERVE) || (r_state == ST_MOVE));

    assign ball_x_l  = r_x_l;
    assign ball_x_r  = r_x_r;
    assign ball_y_t  = r_y_t;
    assign ball_y_b  = r_y_b;
    assign lives     = r_lives;
    assign miss      = r_miss;
    assign game_over = r_game_over;

endmodule

// File: tb/tb_breakout_ball_ctrl.sv
// Bench for breakout_ball_ctrl: a behavioural ball model (integer position,
// +1/-1 directions) checked against the DUT every cycle, directed scenarios
// with hand-computed positions, then randomized play.
module tb_breakout_ball_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        frame_tick;
    logic        btn_launch;
    logic        moveU, moveD, moveL, moveR;
    logic [10:0] paddle_y_t, paddle_y_b, pix_x, pix_y;
    logic [10:0] ball_x_l, ball_x_r, ball_y_t, ball_y_b;
    logic        ball_ON;
    logic [1:0]  lives;
    logic        miss;
    logic        game_over;

    always #5 clk = ~clk;

    breakout_ball_ctrl dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .btn_launch(btn_launch),
        .moveU(moveU), .moveD(moveD), .moveL(moveL), .moveR(moveR),
        .paddle_y_t(paddle_y_t), .paddle_y_b(paddle_y_b), .pix_x(pix_x), .pix_y(pix_y),
        .ball_x_l(ball_x_l), .ball_x_r(ball_x_r), .ball_y_t(ball_y_t), .ball_y_b(ball_y_b),
        .ball_ON(ball_ON), .lives(lives), .miss(miss), .game_over(game_over)
    );

    localparam int MD_SERVE = 0, MD_MOVE = 1, MD_MISS = 2, MD_OVER = 3;

    int m_mode, m_x, m_y, m_dx, m_dy, m_lives, m_cnt;
    bit m_miss, m_btn_q, m_pu, m_pd, m_pl, m_pr;
    int n_vec = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;
    bit saw_miss;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int clampi(input int v, input int hi);
        if (v < 0) return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    task automatic model_reset();
        m_mode = MD_SERVE; m_x = 700; m_y = 296; m_dx = -1; m_dy = -1;
        m_lives = 3; m_cnt = 0; m_miss = 0; m_btn_q = 0;
        m_pu = 0; m_pd = 0; m_pl = 0; m_pr = 0;
    endtask

    // One clock edge of the game rules.
    task automatic model_update();
        bit eu, ed, el, er;
        int old_mode;
        if (reset) begin
            model_reset();
            return;
        end
        eu = m_pu | moveU; ed = m_pd | moveD; el = m_pl | moveL; er = m_pr | moveR;
        old_mode = m_mode;
        m_miss = 0;
        case (m_mode)
            MD_SERVE: begin
                m_x = 700; m_y = 296;
                if (btn_launch && !m_btn_q) begin
                    m_mode = MD_MOVE; m_dx = -1; m_dy = -1;
                end
            end
            MD_MOVE: if (frame_tick) begin
                if (m_x >= 792) begin
                    m_mode = MD_MISS; m_miss = 1; m_cnt = 0;
                    if (m_lives > 0) m_lives--;
                end else begin
                    if (er && el) m_dx = -m_dx; else if (er) m_dx = 1; else if (el) m_dx = -1;
                    if (m_x < 2 && m_dx < 0) m_dx = 1;
                    if (ed && eu) m_dy = -m_dy; else if (ed) m_dy = 1; else if (eu) m_dy = -1;
                    if (m_y < 2 && m_dy < 0) m_dy = 1;
                    else if (m_y + 7 > 597 && m_dy > 0) m_dy = -1;
                    if (m_dx > 0 && m_x + 7 >= 758 && m_x + 7 <= 760 &&
                        m_y + 7 >= int'(paddle_y_t) && m_y <= int'(paddle_y_b)) m_dx = -1;
                    m_x = clampi(m_x + 2 * m_dx, 792);
                    m_y = clampi(m_y + 2 * m_dy, 592);
                end
            end
            MD_MISS: if (frame_tick) begin
                m_cnt++;
                if (m_cnt == 60) begin
                    m_cnt = 0;
                    if (m_lives == 0) m_mode = MD_OVER;
                    else begin m_mode = MD_SERVE; m_x = 700; m_y = 296; end
                end
            end
            default: ;
        endcase
        if (old_mode == MD_SERVE || frame_tick) begin
            m_pu = 0; m_pd = 0; m_pl = 0; m_pr = 0;
        end else begin
            m_pu |= moveU; m_pd |= moveD; m_pl |= moveL; m_pr |= moveR;
        end
        m_btn_q = btn_launch;
    endtask

    // Compare process: DUT outputs against the model every cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            check("ball_x_l", int'(ball_x_l), m_x);
            check("ball_x_r", int'(ball_x_r), m_x + 7);
            check("ball_y_t", int'(ball_y_t), m_y);
            check("ball_y_b", int'(ball_y_b), m_y + 7);
            check("lives", int'(lives), m_lives);
            check("miss", int'(miss), int'(m_miss));
            check("game_over", int'(game_over), int'(m_mode == MD_OVER));
            check("ball_ON", int'(ball_ON),
                  int'((m_mode == MD_SERVE || m_mode == MD_MOVE) &&
                       int'(pix_x) >= m_x && int'(pix_x) <= m_x + 7 &&
                       int'(pix_y) >= m_y && int'(pix_y) <= m_y + 7));
        end
    end

    task automatic cyc();
        @(posedge clk);
        model_update();
        #2;
        if (miss) saw_miss = 1;
        if ($urandom_range(0, 3) == 0) begin
            pix_x = 11'($urandom_range(0, 799));
            pix_y = 11'($urandom_range(0, 599));
        end else begin
            pix_x = 11'(m_x + int'($urandom_range(0, 11)) - 2);
            pix_y = 11'(m_y + int'($urandom_range(0, 11)) - 2);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1; cyc();
            frame_tick = 1'b0; cyc(); cyc(); cyc();
        end
    endtask

    task automatic pulse(input bit u, input bit d, input bit l, input bit r);
        moveU = u; moveD = d; moveL = l; moveR = r;
        cyc();
        moveU = 1'b0; moveD = 1'b0; moveL = 1'b0; moveR = 1'b0;
        cyc();
    endtask

    task automatic pos_is(input string name, input int x, input int y);
        check({name, "_x"}, int'(ball_x_l), x);
        check({name, "_y"}, int'(ball_y_t), y);
    endtask

    task automatic run_to_miss();
        btn_launch = 1'b1; cyc();
        btn_launch = 1'b0; cyc();
        pulse(0, 0, 0, 1);
        saw_miss = 0;
        for (int i = 0; i < 300 && !saw_miss; i++) tick(1);
        check("miss_seen", int'(saw_miss), 1);
        tick(60);
    endtask

    initial begin
        reset = 1'b1; frame_tick = 1'b0; btn_launch = 1'b0;
        moveU = 1'b0; moveD = 1'b0; moveL = 1'b0; moveR = 1'b0;
        paddle_y_t = 11'd0; paddle_y_b = 11'd599; pix_x = 11'd0; pix_y = 11'd0;
        model_reset();
        chk_en = 1'b1;
        cyc(); cyc();
        reset = 1'b0;
        cyc();
        pos_is("reset", 700, 296);
        check("reset_x_r", int'(ball_x_r), 707);
        check("reset_lives", int'(lives), 3);
        check("reset_game_over", int'(game_over), 0);

        // Held button launches once; three ticks up-left.
        btn_launch = 1'b1;
        repeat (10) cyc();
        btn_launch = 1'b0;
        tick(3);
        pos_is("launch3", 694, 290);

        // Top wall: 2 -> 0 -> bounce to 2.
        tick(144);
        pos_is("near_top", 406, 2);
        tick(1);
        pos_is("at_top", 404, 0);
        tick(1);
        pos_is("top_bounce", 402, 2);

        // Left+right together inverts dx; not reapplied on the next tick.
        pulse(0, 0, 1, 1);
        tick(1);
        pos_is("lr_invert", 404, 4);
        tick(1);
        pos_is("lr_no_reapply", 406, 6);
        pulse(1, 0, 0, 0);
        tick(1);
        pos_is("up_req", 408, 4);
        pulse(0, 0, 1, 0);
        tick(1);
        pos_is("left_req", 406, 2);
        pulse(0, 0, 0, 1);
        tick(1);
        pos_is("right_req", 408, 0);
        tick(1);
        pos_is("right_hold", 410, 2);

        // Paddle catch at x_r = 759.
        tick(171);
        pos_is("at_paddle", 752, 344);
        tick(1);
        pos_is("paddle_bounce", 750, 346);

        // Paddle moved away: first miss.
        paddle_y_t = 11'd2000; paddle_y_b = 11'd2040;
        pulse(0, 0, 0, 1);
        tick(1);
        pos_is("to_right", 752, 348);
        tick(20);
        pos_is("at_miss_line", 792, 388);
        check("pre_miss", int'(miss), 0);
        frame_tick = 1'b1; cyc(); frame_tick = 1'b0;
        check("miss_pulse", int'(miss), 1);
        check("miss_lives", int'(lives), 2);
        cyc();
        check("miss_one_clk", int'(miss), 0);
        cyc(); cyc();
        tick(59);
        check("miss_frozen_x", int'(ball_x_l), 792);
        tick(1);
        pos_is("reserve", 700, 296);
        check("reserve_lives", int'(lives), 2);

        run_to_miss();
        check("lives_after_2", int'(lives), 1);
        run_to_miss();
        check("lives_after_3", int'(lives), 0);
        check("game_over_set", int'(game_over), 1);
        btn_launch = 1'b1; cyc(); btn_launch = 1'b0;
        tick(3);
        check("game_over_held", int'(game_over), 1);

        // Reset out of game over, then reset mid-flight.
        reset = 1'b1; model_reset(); cyc();
        reset = 1'b0; cyc();
        check("rst_go_lives", int'(lives), 3);
        check("rst_go_flag", int'(game_over), 0);
        btn_launch = 1'b1; cyc(); btn_launch = 1'b0;
        tick(5);
        reset = 1'b1; model_reset();
        pix_x = 11'd0; pix_y = 11'd0;
        #1;
        pos_is("async_rst", 700, 296);
        check("async_rst_on", int'(ball_ON), 0);
        cyc();
        reset = 1'b0;
        cyc();

        // Randomized play.
        paddle_y_t = 11'd200; paddle_y_b = 11'd260;
        for (int i = 0; i < 12000; i++) begin
            frame_tick = ($urandom_range(0, 3) == 0);
            moveU = ($urandom_range(0, 15) == 0);
            moveD = ($urandom_range(0, 15) == 0);
            moveL = ($urandom_range(0, 15) == 0);
            moveR = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 7) == 0) btn_launch = ~btn_launch;
            if ($urandom_range(0, 63) == 0) begin
                paddle_y_t = 11'($urandom_range(0, 560));
                paddle_y_b = paddle_y_t + 11'd60;
            end
            reset = ($urandom_range(0, 2999) == 0);
            if (reset) model_reset();
            cyc();
        end
        reset = 1'b0; frame_tick = 1'b0;
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
